// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR flag arbiter: the command encoding and the
// index-width helper.
package sr_arb_pkg;

  // A command is the requester's {s, r} pair.
  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_CLR  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_ILL  = 2'b11
  } cmd_e;

  // Index width for n items; never below one bit so ports stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping
// to zero, and moves ptr just past the winner.
module rr_arbiter
  import sr_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int REQ_W = idx_width(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [REQ_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [REQ_W-1:0] ptr_q, ptr_d;
  logic [REQ_W:0]   cand;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (REQ_W+1)'(i);
      if (cand >= (REQ_W+1)'(NREQ)) cand = cand - (REQ_W+1)'(NREQ);
      // Reset gates the grant asynchronously, not just via the pointer.
      if (!gnt_any && rst_n && req[cand[REQ_W-1:0]]) begin
        gnt_any                = 1'b1;
        gnt_idx                = cand[REQ_W-1:0];
        gnt[cand[REQ_W-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == REQ_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of SR flags shared by several requesters; one round-robin-granted
// set/clear/hold command per cycle, with sticky capture of the first s=r=1.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NFLAG = 8,
  localparam int IDX_W = idx_width(NFLAG),
  localparam int REQ_W = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_s,
  input  logic [NREQ-1:0]       req_r,
  input  logic [NREQ*IDX_W-1:0] req_idx,
  output logic [NREQ-1:0]       gnt,
  output logic [NFLAG-1:0]      q,
  output logic [NFLAG-1:0]      qbar,
  output logic                  err,
  output logic [REQ_W-1:0]      err_req,
  output logic [IDX_W-1:0]      err_idx
);

  localparam int unsigned NFLAG_U = NFLAG;

  logic [REQ_W-1:0] gnt_idx;
  logic             gnt_any;
  cmd_e             sel_cmd;
  logic [IDX_W-1:0] sel_idx;
  logic             idx_ok;

  logic [NFLAG-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [REQ_W-1:0] err_req_q, err_req_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign sel_cmd = cmd_e'({req_s[gnt_idx], req_r[gnt_idx]});
  assign sel_idx = req_idx[int'(gnt_idx)*IDX_W +: IDX_W];
  assign idx_ok  = ({{(32-IDX_W){1'b0}}, sel_idx} < NFLAG_U);

  // Unknown or out-of-range commands fall to the hold path, so X never
  // propagates into the bank.
  always_comb begin
    q_d       = q_q;
    err_d     = err_q;
    err_req_d = err_req_q;
    err_idx_d = err_idx_q;
    if (gnt_any && idx_ok) begin
      case (sel_cmd)
        CMD_SET: q_d[sel_idx] = 1'b1;
        CMD_CLR: q_d[sel_idx] = 1'b0;
        CMD_ILL: begin
          if (!err_q) begin
            err_d     = 1'b1;
            err_req_d = gnt_idx;
            err_idx_d = sel_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= '0;
      err_q     <= 1'b0;
      err_req_q <= '0;
      err_idx_q <= '0;
    end else begin
      q_q       <= q_d;
      err_q     <= err_d;
      err_req_q <= err_req_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign q       = q_q;
  assign qbar    = ~q_q;
  assign err     = err_q;
  assign err_req = err_req_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter with NREQ=4, NFLAG=8.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_s = '0;
  logic [3:0]  req_r = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  gnt;
  logic [7:0]  q, qbar;
  logic        err;
  logic [1:0]  err_req;
  logic [2:0]  err_idx;

  int n_tests = 0;
  int n_fail  = 0;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_s     (req_s),
    .req_r     (req_r),
    .req_idx   (req_idx),
    .gnt       (gnt),
    .q         (q),
    .qbar      (qbar),
    .err       (err),
    .err_req   (err_req),
    .err_idx   (err_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic s,
                         input logic r, input logic [2:0] idx);
    req_valid[i]     = v;
    req_s[i]         = s;
    req_r[i]         = r;
    req_idx[i*3 +: 3] = idx;
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_s     = '0;
    req_r     = '0;
    req_idx   = '0;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 4'($urandom);
    req_s     = 4'($urandom);
    req_r     = 4'($urandom);
    req_idx   = 12'($urandom);
    tick();
    tick();
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h exp 00", q); end
    n_tests++; if (qbar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar: got %h exp FF", qbar); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
    n_tests++; if ({err, err_req, err_idx} !== 6'b0) begin n_fail++;
      $display("FAIL reset_err: got err=%b req=%0d idx=%0d exp 0/0/0", err, err_req, err_idx); end
    clear_reqs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_set();
    set_req(0, 1'b1, 1'b1, 1'b0, 3'd3);
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b exp 0001", gnt); end
    tick();
    clear_reqs();
    n_tests++; if (q !== 8'h08) begin n_fail++; $display("FAIL single_set_q: got %h exp 08", q); end
    n_tests++; if (qbar !== 8'hF7) begin n_fail++; $display("FAIL single_set_qbar: got %h exp F7", qbar); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b exp 0000", gnt); end
    set_req(0, 1'b1, 1'b0, 1'b1, 3'd3);
    tick();
    clear_reqs();
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL single_clr_q: got %h exp 00", q); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q;
    logic [3:0] exp_gnt;
    // ptr is 1 here; a hold from requester 3 wraps it back to 0.
    set_req(3, 1'b1, 1'b0, 1'b0, 3'd0);
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rr_prep_gnt: got %b exp 1000", gnt); end
    tick();
    clear_reqs();
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL rr_prep_q: got %h exp 00", q); end
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 1'b0, 3'(i));
    exp_q = 8'h00;
    for (int c = 0; c < 5; c++) begin
      exp_gnt = 4'b0001 << (c % 4);
      exp_q   = exp_q | (8'h01 << (c % 4));
      n_tests++; if (gnt !== exp_gnt) begin n_fail++;
        $display("FAIL rr_gnt[%0d]: got %b exp %b", c, gnt, exp_gnt); end
      tick();
      n_tests++; if (q !== exp_q) begin n_fail++;
        $display("FAIL rr_q[%0d]: got %h exp %h", c, q, exp_q); end
    end
    clear_reqs();
  endtask

  task automatic test_illegal();
    // ptr is 1; requester 1 sets flag 5 first.
    set_req(1, 1'b1, 1'b1, 1'b0, 3'd5);
    tick();
    clear_reqs();
    n_tests++; if (q !== 8'h2F) begin n_fail++; $display("FAIL ill_pre_q: got %h exp 2F", q); end
    set_req(2, 1'b1, 1'b1, 1'b1, 3'd5);
    n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL ill_gnt: got %b exp 0100", gnt); end
    tick();
    clear_reqs();
    n_tests++; if (q !== 8'h2F) begin n_fail++; $display("FAIL ill_q: got %h exp 2F", q); end
    n_tests++; if ({err, err_req, err_idx} !== {1'b1, 2'd2, 3'd5}) begin n_fail++;
      $display("FAIL ill_err: got err=%b req=%0d idx=%0d exp 1/2/5", err, err_req, err_idx); end
    // ptr is 3; requester 1 wins after the wrap.
    set_req(1, 1'b1, 1'b1, 1'b1, 3'd6);
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ill2_gnt: got %b exp 0010", gnt); end
    tick();
    clear_reqs();
    n_tests++; if ({err, err_req, err_idx} !== {1'b1, 2'd2, 3'd5}) begin n_fail++;
      $display("FAIL ill2_sticky: got err=%b req=%0d idx=%0d exp 1/2/5", err, err_req, err_idx); end
    n_tests++; if (q !== 8'h2F) begin n_fail++; $display("FAIL ill2_q: got %h exp 2F", q); end
  endtask

  task automatic test_hold_contention();
    // ptr is 2; a hold from requester 0 moves it to 1.
    set_req(0, 1'b1, 1'b0, 1'b0, 3'd1);
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL hc_prep_gnt: got %b exp 0001", gnt); end
    tick();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 1'b0, 3'd0);
    set_req(3, 1'b1, 1'b1, 1'b0, 3'd7);
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL hc_gnt1: got %b exp 0010", gnt); end
    tick();
    set_req(1, 1'b0, 1'b0, 1'b0, 3'd0);
    n_tests++; if (q !== 8'h2F) begin n_fail++; $display("FAIL hc_hold_q: got %h exp 2F", q); end
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL hc_gnt3: got %b exp 1000", gnt); end
    tick();
    clear_reqs();
    n_tests++; if (q !== 8'hAF) begin n_fail++; $display("FAIL hc_set_q: got %h exp AF", q); end
  endtask

  task automatic test_reset_mid();
    // Drive q from AF to F0 through requester 0.
    logic [3:0] ops [6];
    ops = '{4'b0_000, 4'b0_001, 4'b0_010, 4'b0_011, 4'b1_100, 4'b1_110};
    foreach (ops[n]) begin
      set_req(0, 1'b1, ops[n][3], ~ops[n][3], ops[n][2:0]);
      tick();
      clear_reqs();
    end
    n_tests++; if (q !== 8'hF0) begin n_fail++; $display("FAIL mid_pre_q: got %h exp F0", q); end
    set_req(0, 1'b1, 1'b1, 1'b0, 3'd0);
    set_req(1, 1'b1, 1'b1, 1'b0, 3'd1);
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_pre_gnt: got %b exp 0010", gnt); end
    #1 rst = 1'b0;
    #1;
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL mid_rst_q: got %h exp 00", q); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt: got %b exp 0000", gnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b exp 0", err); end
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_rel_gnt: got %b exp 0001", gnt); end
    tick();
    n_tests++; if (q !== 8'h01) begin n_fail++; $display("FAIL mid_rel_q: got %h exp 01", q); end
    n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_next_gnt: got %b exp 0010", gnt); end
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_illegal();
    test_hold_contention();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shares one bank of NFLAG set/reset flag bits between NREQ requesters.
- Each requester issues set, clear or no-op commands against a flag index. A round-robin arbiter grants one command per cycle, and the granted command updates the flag bank.
- Resolves the SR forbidden case (s=r=1) deterministically: no flag change plus a sticky error. Unknown values never reach the flag bank.
- Sits between control agents and status/flag logic built from SR flops.

Parameters:
- NREQ, 4, number of requesters (2..16)
- NFLAG, 8, number of SR flags in the bank (2..64)
- IDX_W, $clog2(NFLAG), flag index width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_s  in  NREQ  per-requester set bit
- req_r  in  NREQ  per-requester reset bit
- req_idx  in  NREQ*IDX_W  flattened flag index; requester i uses bits [i*IDX_W +: IDX_W]
- gnt  out  NREQ  one-hot grant (combinational, same cycle as the accepted valid)
- q  out  NFLAG  flag bank state
- qbar  out  NFLAG  ~q
- err  out  1  sticky: a granted command had s=r=1
- err_req  out  $clog2(NREQ)  requester that caused the first error
- err_idx  out  IDX_W  flag index of the first error

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-low. While rst=0:
  - q=0, qbar=all ones, err=0, err_req=0, err_idx=0
  - round-robin pointer ptr=0, gnt=0
- Handshake: valid/grant.
  - The requester holds req_valid, req_s, req_r and req_idx stable until it sees gnt[i]=1 in a cycle.
  - The transfer completes on the rising edge where req_valid[i] & gnt[i].
  - The requester may present its next command in the following cycle.
- Arbitration:
  - Each cycle, grant the first valid requester searching from ptr upward, wrapping NREQ-1 -> 0.
  - At most one grant per cycle. gnt=0 when no req_valid is set.
  - gnt depends only on req_valid and ptr, never on req_s, req_r or req_idx.
- Pointer update: on a grant to requester k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
- Command decode for the granted requester at flag j=req_idx, applied at the clock edge:
  - s=0 r=0: hold, q[j] unchanged (still granted and consumed)
  - s=1 r=0: q[j] <= 1
  - s=0 r=1: q[j] <= 0
  - s=1 r=1: q[j] unchanged. If err=0: err<=1, err_req<=k, err_idx<=j. If err=1: err_req and err_idx keep the first error.
- Out-of-range index (req_idx >= NFLAG, when NFLAG is not a power of two): the command is granted and ignored, q unchanged, no error.
- Latency:
  - grant is in the same cycle as valid when the requester is highest priority
  - q reflects the command 1 cycle after the accepting edge (registered)
  - qbar is combinational from q
- Only the flag addressed by the granted command changes; all other flags hold.
- err is cleared only by reset.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.
- Reset asserted mid-operation: all state clears immediately and gnt drops asynchronously. Pending requesters keep valid and are re-arbitrated from ptr=0 after rst rises; the first edge after release may grant.

Decomposition:
- Package sr_arb_pkg:
  - command encoding constants CMD_HOLD=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_ILL=2'b11, built as {s,r}
  - function for the clog2-based widths
- Sub-module rr_arbiter:
  - NREQ-wide round-robin arbiter: req in, one-hot gnt out, gnt_idx out, own ptr register with async active-low reset
  - reused elsewhere
- The top level holds the flag bank, command decode and error capture.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with random requests -> q=8'h00, qbar=8'hFF, gnt=0, err=0. Release rst.
- Single set: req0 valid with s=1, r=0, idx=3 -> gnt=4'b0001 the same cycle. Next cycle q=8'h08. Then req0 s=0 r=1 idx=3 -> q=8'h00.
- Round robin: requesters 0..3 all valid continuously, each setting its own idx 0..3 -> grants 0001, 0010, 0100, 1000, then wrap to 0001. q goes 01 -> 03 -> 07 -> 0F.
- Illegal command: req2 s=1 r=1 idx=5 with q[5]=1 -> q[5] stays 1, err=1, err_req=2, err_idx=5. A second illegal command from req1 idx=6 leaves err_req=2 and err_idx=5.
- Hold plus contention: req1 hold idx=0 and req3 set idx=7 both valid with ptr=1 -> req1 granted first with q unchanged, req3 next cycle with q[7]=1.
- Reset mid-operation: assert rst=0 between clock edges while req0 and req1 are valid and q=8'hF0 -> q=0 and gnt=0 immediately. After release, req0 is granted first (ptr=0).
